timer_counter: RTL and testbench

- Programmable down-counting timer peripheral on the CPU device bus, behind the bus bridge.
- Two instances are mapped: TC0 at 0x7F00–0x7F0B and TC1 at 0x7F10–0x7F1B.
- The bridge supplies the address and write data and a per-device write enable, and returns this block's read data to the CPU.
- The block sequences its own counting through a four-state FSM and raises an interrupt request, which the bridge routes into hwint[0] (TC0) or hwint[1] (TC1).

---
 rtl/timer_counter.sv | 135 +++++++++++++
 tb/tb_timer_counter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: programmable down-counting timer with CTRL/PRESET/COUNT
// registers on the device bus and a maskable interrupt request.
module timer_counter #(
  parameter int unsigned CTRL_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_CNT  = 2'b10,
    S_INT  = 2'b11
  } state_t;

  state_t                 state, state_next;
  logic [CTRL_BITS-1:0]   ctrl;
  logic [31:0]            preset;
  logic [31:0]            count, count_next;
  logic                   int_flag;
  logic                   flag_set;
  logic                   en_clr;

  logic                   enable;
  logic [1:0]             mode;
  logic                   im;
  logic                   wr_ctrl;
  logic                   wr_preset;

  // Only addr[3:2] selects a register; the rest is decoded by the bridge.
  logic                   unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign enable    = ctrl[0];
  assign mode      = ctrl[2:1];
  assign im        = ctrl[3];
  assign wr_ctrl   = we && (addr[3:2] == 2'b00);
  assign wr_preset = we && (addr[3:2] == 2'b01);

  assign irq = int_flag & im;

  // Read mux: combinational on the register select, no side effects.
  always_comb begin
    rd = '0;
    case (addr[3:2])
      2'b00:   rd = 32'(ctrl);
      2'b01:   rd = preset;
      2'b10:   rd = count;
      default: rd = '0;
    endcase
  end

  // Next-state and count update; INT raises the flag and, in one-shot
  // modes, requests the Enable bit to drop.
  always_comb begin
    state_next = state;
    count_next = count;
    flag_set   = 1'b0;
    en_clr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_next = S_LOAD;
      end
      S_LOAD: begin
        count_next = preset;
        state_next = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (count > 32'd1) begin
          count_next = count - 32'd1;
        end else begin
          count_next = '0;
          state_next = S_INT;
        end
      end
      S_INT: begin
        flag_set = 1'b1;
        if (mode == 2'b01) begin
          state_next = S_LOAD;
        end else begin
          en_clr     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state and counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // CPU-visible configuration; a CPU CTRL write overrides the INT Enable clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= '0;
      preset <= '0;
    end else begin
      if (wr_ctrl)     ctrl    <= wd[CTRL_BITS-1:0];
      else if (en_clr) ctrl[0] <= 1'b0;
      if (wr_preset)   preset  <= wd;
    end
  end

  // Interrupt flag. Periodic mode always passes INT -> LOAD, and LOAD is
  // otherwise only reachable after a CTRL write (which already cleared the
  // flag), so clearing in LOAD yields the one-cycle periodic pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_flag <= 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      int_flag <= 1'b0;
    end else if (flag_set) begin
      int_flag <= 1'b1;
    end else if (state == S_LOAD) begin
      int_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed vector table plus hand-written sequences for
// the periodic, pause/resume, zero-preset, mask, collision and reset cases.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int unsigned n_vec;
  int unsigned n_err;

  timer_counter #(.CTRL_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rd, exp);
  endtask

  initial begin
    logic [31:0] m1_cnt [15];
    logic        m1_irq [15];
    logic        z_irq  [7];

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    addr  = '0;
    we    = 1'b0;
    wd    = '0;

    tbl[0]  = '{32'h7F00, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[1]  = '{32'h7F04, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[2]  = '{32'h7F08, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[3]  = '{32'h7F0C, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[4]  = '{32'h7F04, 1'b1, 32'h5,        32'h0, 1'b0};
    tbl[5]  = '{32'h7F00, 1'b1, 32'h9,        32'h0, 1'b0};
    tbl[6]  = '{32'h7F08, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[7]  = '{32'h7F08, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[8]  = '{32'h7F08, 1'b0, 32'h0,        32'h5, 1'b0};
    tbl[9]  = '{32'h7F08, 1'b0, 32'h0,        32'h4, 1'b0};
    tbl[10] = '{32'h7F08, 1'b0, 32'h0,        32'h3, 1'b0};
    tbl[11] = '{32'h7F08, 1'b0, 32'h0,        32'h2, 1'b0};
    tbl[12] = '{32'h7F08, 1'b0, 32'h0,        32'h1, 1'b0};
    tbl[13] = '{32'h7F08, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[14] = '{32'h7F00, 1'b0, 32'h0,        32'h8, 1'b1};
    tbl[15] = '{32'h7F08, 1'b0, 32'h0,        32'h0, 1'b1};
    tbl[16] = '{32'h7F00, 1'b0, 32'h0,        32'h8, 1'b1};
    tbl[17] = '{32'h7F04, 1'b1, 32'h7,        32'h5, 1'b1};
    tbl[18] = '{32'h7F04, 1'b0, 32'h0,        32'h7, 1'b0};
    tbl[19] = '{32'h7F08, 1'b1, 32'h1234,     32'h0, 1'b0};
    tbl[20] = '{32'h7F0C, 1'b1, 32'hFFFF,     32'h0, 1'b0};
    tbl[21] = '{32'h7F08, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[22] = '{32'h7F00, 1'b1, 32'hFFFFFFF0, 32'h8, 1'b0};
    tbl[23] = '{32'h7F00, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[24] = '{32'h7F04, 1'b0, 32'h0,        32'h7, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state, one-shot mode 0, PRESET-write irq clear, ignored writes.
    for (int unsigned i = 0; i < 25; i++) begin
      addr = tbl[i].a;
      wd   = tbl[i].d;
      we   = tbl[i].w;
      #1;
      chk($sformatf("tbl[%0d].rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl[%0d].irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
      @(negedge clk);
      we = 1'b0;
    end

    // Mode 1 periodic, PRESET = 3: period LOAD + 3 CNT + INT = 5 cycles.
    m1_cnt = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3, 2, 1};
    m1_irq = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    bus_write(32'h7F04, 32'd3);
    bus_write(32'h7F00, 32'hB);
    for (int unsigned i = 0; i < 15; i++) begin
      read_chk($sformatf("m1.count[%0d]", i), 32'h7F08, m1_cnt[i]);
      chk($sformatf("m1.irq[%0d]", i), {31'b0, irq}, {31'b0, m1_irq[i]});
      @(negedge clk);
    end
    read_chk("m1.ctrl", 32'h7F00, 32'hB);
    bus_write(32'h7F00, 32'h0);
    repeat (5) @(negedge clk);

    // Pause at COUNT = 6, freeze at 5, resume reloads PRESET.
    bus_write(32'h7F04, 32'd10);
    bus_write(32'h7F00, 32'h9);
    repeat (2) @(negedge clk);
    for (int unsigned i = 0; i < 5; i++) begin
      read_chk($sformatf("pause.count[%0d]", i), 32'h7F08, 32'd10 - 32'(i));
      if (i < 4) @(negedge clk);
    end
    bus_write(32'h7F00, 32'h8);
    for (int unsigned i = 0; i < 4; i++) begin
      read_chk($sformatf("pause.frozen[%0d]", i), 32'h7F08, 32'd5);
      chk("pause.irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
    end
    bus_write(32'h7F00, 32'h9);
    read_chk("resume.idle", 32'h7F08, 32'd5);
    @(negedge clk);
    read_chk("resume.load", 32'h7F08, 32'd5);
    @(negedge clk);
    read_chk("resume.reload", 32'h7F08, 32'd10);
    @(negedge clk);
    read_chk("resume.dec", 32'h7F08, 32'd9);
    bus_write(32'h7F00, 32'h0);
    repeat (3) @(negedge clk);

    // PRESET = 0: irq three edges after the LOAD edge, never a wrap.
    z_irq = '{0, 0, 0, 0, 1, 1, 1};
    bus_write(32'h7F04, 32'd0);
    bus_write(32'h7F00, 32'h9);
    for (int unsigned i = 0; i < 7; i++) begin
      addr = 32'h7F08;
      #1;
      chk($sformatf("zero.irq[%0d]", i), {31'b0, irq}, {31'b0, z_irq[i]});
      if (i >= 2) chk($sformatf("zero.count[%0d]", i), rd, 32'h0);
      if (rd == 32'hFFFFFFFF) chk("zero.nowrap", rd, 32'h0);
      @(negedge clk);
    end
    read_chk("zero.ctrl", 32'h7F00, 32'h8);

    // IM = 0: the run completes but irq never asserts.
    bus_write(32'h7F00, 32'h1);
    for (int unsigned i = 0; i < 6; i++) begin
      chk($sformatf("nomask.irq[%0d]", i), {31'b0, irq}, 32'h0);
      @(negedge clk);
    end
    read_chk("nomask.ctrl", 32'h7F00, 32'h0);

    // Collision: CTRL write on the INT edge keeps Enable and clears the flag.
    bus_write(32'h7F04, 32'd2);
    bus_write(32'h7F00, 32'h9);
    repeat (4) @(negedge clk);
    read_chk("coll.int_count", 32'h7F08, 32'd0);
    bus_write(32'h7F00, 32'h9);
    read_chk("coll.ctrl", 32'h7F00, 32'h9);
    chk("coll.irq0", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("coll.irq1", {31'b0, irq}, 32'h0);
    @(negedge clk);
    read_chk("coll.reload", 32'h7F08, 32'd2);

    // Reset mid-count returns everything to reset values.
    bus_write(32'h7F04, 32'd10);
    bus_write(32'h7F00, 32'h9);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_chk("rst.ctrl", 32'h7F00, 32'h0);
    read_chk("rst.preset", 32'h7F04, 32'h0);
    read_chk("rst.count", 32'h7F08, 32'h0);
    chk("rst.irq", {31'b0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    read_chk("rst.count_idle", 32'h7F08, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
